// File: rtl/rom_playback_ctrl.sv
// rom_playback_ctrl
//   Sequencer for the ROM display datapath. It conditions the three board
//   buttons with a synchronizer and debouncer. It runs a PAUSED/RUN mode with
//   three playback speeds. It steps the ROM read address at the selected rate
//   and pulses word_load when the ROM word for the current address is valid.
//
// Ports
//   clk        in   system clock, all flops rising-edge
//   rst_n      in   asynchronous active-low reset
//   btn_p      in   raw pause/resume button (async, active-high)
//   btn_spdup  in   raw speed-up button (async, active-high)
//   btn_spddn  in   raw speed-down button (async, active-high)
//   rom_addr   out  registered ROM read address
//   word_load  out  1-cycle pulse: ROM data for rom_addr is valid
//   st         out  00 PAUSED, 01 RUN_SLOW, 10 RUN_NORMAL, 11 RUN_FAST
//   tick_led   out  toggles on every address step
module rom_playback_ctrl #(
  parameter int CLK_FREQ = 500,
  parameter int ADDR_W   = 7,
  parameter int ADDR_MAX = 127,
  parameter int DEB_CYC  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_p,
  input  logic              btn_spdup,
  input  logic              btn_spddn,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              word_load,
  output logic [1:0]        st,
  output logic              tick_led
);

  localparam int TMR_W    = $clog2(4 * CLK_FREQ);
  localparam int DEB_W    = $clog2(DEB_CYC);
  localparam int FAST_PER = (CLK_FREQ / 4 > 0) ? (CLK_FREQ / 4) : 1;

  localparam logic [TMR_W-1:0]  LAST_SLOW = TMR_W'(4 * CLK_FREQ - 1);
  localparam logic [TMR_W-1:0]  LAST_NORM = TMR_W'(CLK_FREQ - 1);
  localparam logic [TMR_W-1:0]  LAST_FAST = TMR_W'(FAST_PER - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYC - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(ADDR_MAX);

  typedef enum logic {
    MODE_PAUSED = 1'b0,
    MODE_RUN    = 1'b1
  } mode_e;

  // Encoded so that the speed value is directly the RUN state code on st.
  typedef enum logic [1:0] {
    SPD_SLOW   = 2'b01,
    SPD_NORMAL = 2'b10,
    SPD_FAST   = 2'b11
  } speed_e;

  // Button vectors: bit 0 pause, bit 1 speed-up, bit 2 speed-down.
  logic [2:0]            sync1_q, sync1_d;
  logic [2:0]            sync2_q, sync2_d;
  logic [2:0]            stable_q, stable_d;
  logic [2:0]            stable_dly_q, stable_dly_d;
  logic [2:0]            press_q, press_d;
  logic [2:0][DEB_W-1:0] deb_cnt_q, deb_cnt_d;

  mode_e             mode_q, mode_d;
  speed_e            speed_q, speed_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [TMR_W-1:0]  tmr_last;
  logic              step;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              tick_q, tick_d;
  logic              upd_q, upd_d;
  logic              boot_q, boot_d;
  logic              load_q, load_d;
  logic [1:0]        st_q, st_d;

  // Button conditioning. A level change is only accepted after the
  // synchronized input has disagreed with the stable level for DEB_CYC
  // consecutive cycles. The press pulse comes from a delayed copy of the
  // stable level, so it is a clean registered 1-cycle pulse on rising edges.
  always_comb begin
    sync1_d      = {btn_spddn, btn_spdup, btn_p};
    sync2_d      = sync1_q;
    stable_d     = stable_q;
    deb_cnt_d    = deb_cnt_q;
    stable_dly_d = stable_q;
    press_d      = stable_q & ~stable_dly_q;
    for (int i = 0; i < 3; i++) begin
      if (sync2_q[i] == stable_q[i]) begin
        deb_cnt_d[i] = '0;
      end else if (deb_cnt_q[i] == DEB_LAST) begin
        stable_d[i]  = sync2_q[i];
        deb_cnt_d[i] = '0;
      end else begin
        deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
      end
    end
  end

  // Mode/speed control. Pause outranks speed-up, which outranks speed-down;
  // a lower-priority press in the same cycle is simply lost. Speed changes are
  // accepted while paused and take effect on resume.
  always_comb begin
    mode_d  = mode_q;
    speed_d = speed_q;
    if (press_q[0]) begin
      mode_d = (mode_q == MODE_RUN) ? MODE_PAUSED : MODE_RUN;
    end else if (press_q[1]) begin
      case (speed_q)
        SPD_SLOW:   speed_d = SPD_NORMAL;
        SPD_NORMAL: speed_d = SPD_FAST;
        default:    speed_d = SPD_FAST;
      endcase
    end else if (press_q[2]) begin
      case (speed_q)
        SPD_FAST:   speed_d = SPD_NORMAL;
        SPD_NORMAL: speed_d = SPD_SLOW;
        default:    speed_d = SPD_SLOW;
      endcase
    end
    st_d = (mode_d == MODE_RUN) ? speed_d : 2'b00;
  end

  // Step timer. It counts only in RUN and holds while paused, so a resume
  // finishes the interrupted period. A real speed change restarts the period,
  // but a step due in that same cycle is still issued.
  always_comb begin
    case (speed_q)
      SPD_SLOW: tmr_last = LAST_SLOW;
      SPD_FAST: tmr_last = LAST_FAST;
      default:  tmr_last = LAST_NORM;
    endcase
    step  = (mode_q == MODE_RUN) && (tmr_q >= tmr_last);
    tmr_d = tmr_q;
    if (mode_q == MODE_RUN) begin
      tmr_d = step ? '0 : tmr_q + 1'b1;
    end
    if (speed_d != speed_q) begin
      tmr_d = '0;
    end
  end

  // Address stepping and load pulse. upd_q marks the cycle in which rom_addr
  // took a new value. The ROM needs one more cycle, so word_load is upd_q
  // delayed by one. boot_q forces a single load of address 0 after reset.
  always_comb begin
    addr_d = addr_q;
    if (step) begin
      addr_d = (addr_q == ADDR_LAST) ? '0 : addr_q + 1'b1;
    end
    tick_d = tick_q ^ step;
    upd_d  = step | ~boot_q;
    boot_d = 1'b1;
    load_d = upd_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      stable_q     <= '0;
      stable_dly_q <= '0;
      press_q      <= '0;
      deb_cnt_q    <= '0;
      mode_q       <= MODE_PAUSED;
      speed_q      <= SPD_NORMAL;
      tmr_q        <= '0;
      addr_q       <= '0;
      tick_q       <= 1'b0;
      upd_q        <= 1'b0;
      boot_q       <= 1'b0;
      load_q       <= 1'b0;
      st_q         <= 2'b00;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_dly_d;
      press_q      <= press_d;
      deb_cnt_q    <= deb_cnt_d;
      mode_q       <= mode_d;
      speed_q      <= speed_d;
      tmr_q        <= tmr_d;
      addr_q       <= addr_d;
      tick_q       <= tick_d;
      upd_q        <= upd_d;
      boot_q       <= boot_d;
      load_q       <= load_d;
      st_q         <= st_d;
    end
  end

  assign rom_addr  = addr_q;
  assign word_load = load_q;
  assign st        = st_q;
  assign tick_led  = tick_q;

endmodule
